rw_step_counter: RTL and testbench
==================================

# rw_step_counter

Parametrised successor to the single-state 8-bit step device used in the ReWire regression designs. It holds one WIDTH-bit state register. While running, the register advances by STEP every cycle. A valid-qualified command port lets the upstream logic step, decrement, load or pause/resume the counter. The block sits between command-generating logic and any consumer of a free-running, controllable sequence value, and exposes the registered state, a run flag and a wrap/saturate flag.

## Interface
- WIDTH, 8, state/output width in bits (≥2)
- STEP, 1, auto-advance increment, 1 ≤ STEP < 2^WIDTH
- INIT, 0, state value after reset, WIDTH bits
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  command qualifier
- in_op  input  2  command: 00 step, 01 decrement, 10 load, 11 pause/resume toggle
- in_data  input  WIDTH  load value; used only when in_op=10
- out_q  output  WIDTH  registered state value
- out_run  output  1  1 = RUN state, 0 = PAUSED
- out_carry  output  1  one-cycle pulse on wrap (or saturation hit)

## Operation
- FSM with two states, RUN and PAUSED. Reset enters RUN.
- The table below is the next-state rule, evaluated every rising edge. First matching row wins.
  - in_valid=1, in_op=10: q ← in_data. FSM state unchanged. carry ← 0.
  - in_valid=1, in_op=11: FSM toggles RUN↔PAUSED. q held. carry ← 0.
  - in_valid=1, in_op=00: q ← q + STEP, in either state.
  - in_valid=1, in_op=01: q ← q − 1, in either state.
  - in_valid=0, RUN: q ← q + STEP.
  - in_valid=0, PAUSED: q held. carry ← 0.
- Arithmetic is computed at WIDTH+1 bits.
- Increment: carry ← bit WIDTH of (q + STEP).
- Decrement: carry ← 1 if q = 0, otherwise 0.
- Without saturation, the result is truncated to WIDTH bits, i.e. modulo 2^WIDTH.
- Explicit step and decrement are applied even in PAUSED and leave the FSM in PAUSED.
- Load in PAUSED leaves the FSM in PAUSED.
- in_data is ignored unless in_op=10. in_op is ignored when in_valid=0.
- Reset values: out_q=INIT, out_run=1, out_carry=0.

## Timing
- All outputs are registered. There is no combinational path from input to output.
- Command latency is 1 cycle: a command sampled at edge n is visible on out_q, out_run and out_carry after edge n.
- out_carry is high for exactly one cycle per wrap event. Back-to-back wraps give back-to-back pulses.
- Auto-advance needs no handshake. The block accepts one command every cycle with no backpressure.
- Reset asserted mid-cycle forces reset values immediately, independent of clk. Any in-flight command is lost.
- Leaving reset: the first edge with rst=0 performs a normal update from INIT.

## Configuration
- Macro: RW_STEP_COUNTER_SAT_EN.
- Defined (saturating mode):
  - An increment that would exceed 2^WIDTH−1 clamps q to 2^WIDTH−1.
  - A decrement from 0 holds q at 0.
  - out_carry pulses only on the cycle the clamp first takes effect, i.e. the result changes to the limit or would have wrapped from a non-limit value. Subsequent clamped cycles at the limit do not pulse.
  - In RUN at the max value, q stays at max with carry=0 after the first pulse.
- Undefined (wrap mode): modulo behaviour as described in Operation. This is the default.

## Test plan
- Reset, RUN, carry: WIDTH=8, STEP=1, INIT=0. Assert rst, release, 5 idle cycles → out_q 0→1→2→3→4→5, out_run=1, out_carry=0 throughout.
- Wrap: load 8'hFE, then idle 3 cycles → out_q FE, FF, 00, 01. out_carry=1 only in the cycle out_q=00. With RW_STEP_COUNTER_SAT_EN: FE, FF, FF, FF, with carry=1 only on the first FF.
- Pause: toggle (op 11) at out_q=10, idle 4 cycles → out_q stays 10 and out_run=0. Issue step (op 00) → 11, still paused. Toggle again → resumes at 12, 13.
- Decrement underflow: load 00, then decrement → out_q=FF with carry pulse. With RW_STEP_COUNTER_SAT_EN: out_q stays 00 with one carry pulse.
- Async reset mid-run: assert rst between edges while out_q=37 → out_q=INIT, out_run=1, out_carry=0 before the next edge. A load issued on the reset cycle has no effect.
- STEP=3, WIDTH=4: idle from INIT=0xD → 0xD, 0x0 (carry=1), 0x3, 0x6.

Source files
------------

// File: rtl/rw_step_counter.sv
// Controllable free-running step counter with RUN/PAUSED FSM and a wrap/saturate flag.
// Define RW_STEP_COUNTER_SAT_EN to clamp at the limits instead of wrapping modulo 2^WIDTH.
module rw_step_counter #(
    parameter int unsigned     WIDTH = 8,
    parameter int unsigned     STEP  = 1,
    parameter logic [WIDTH-1:0] INIT = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] out_q,
    output logic             out_run,
    output logic             out_carry
);

    localparam logic [WIDTH:0] STEP_EXT = (WIDTH+1)'(STEP);

    typedef enum logic {StPaused = 1'b0, StRun = 1'b1} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] q_q;
    logic             carry_q;

    logic [WIDTH:0]   inc_sum;
    logic [WIDTH-1:0] inc_q;
    logic             inc_c;
    logic [WIDTH-1:0] dec_q;
    logic             dec_c;

    always_comb begin
        inc_sum = {1'b0, q_q} + STEP_EXT;
        dec_c   = (q_q == '0);
`ifdef RW_STEP_COUNTER_SAT_EN
        // Pulse only when the limit is first reached, not while sitting on it.
        inc_q = inc_sum[WIDTH] ? {WIDTH{1'b1}} : inc_sum[WIDTH-1:0];
        inc_c = (inc_sum >= {1'b0, {WIDTH{1'b1}}}) && (q_q != {WIDTH{1'b1}});
        dec_q = dec_c ? '0 : q_q - 1'b1;
`else
        inc_q = inc_sum[WIDTH-1:0];
        inc_c = inc_sum[WIDTH];
        dec_q = q_q - 1'b1;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StRun;
            q_q     <= INIT;
            carry_q <= 1'b0;
        end else if (in_valid) begin
            unique case (in_op)
                2'b10: begin
                    q_q     <= in_data;
                    carry_q <= 1'b0;
                end
                2'b11: begin
                    state_q <= (state_q == StRun) ? StPaused : StRun;
                    carry_q <= 1'b0;
                end
                2'b00: begin
                    q_q     <= inc_q;
                    carry_q <= inc_c;
                end
                2'b01: begin
                    q_q     <= dec_q;
                    carry_q <= dec_c;
                end
            endcase
        end else begin
            unique case (state_q)
                StRun: begin
                    q_q     <= inc_q;
                    carry_q <= inc_c;
                end
                StPaused: carry_q <= 1'b0;
            endcase
        end
    end

    assign out_q     = q_q;
    assign out_run   = (state_q == StRun);
    assign out_carry = carry_q;

endmodule

// File: tb/tb_rw_step_counter.sv
// Directed bench for rw_step_counter: 8-bit/STEP=1 instance plus a 4-bit/STEP=3 instance.
module tb_rw_step_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [1:0] in_op;
    logic [7:0] in_data;
    logic [7:0] out_q;
    logic       out_run;
    logic       out_carry;

    logic       b_valid;
    logic [1:0] b_op;
    logic [3:0] b_data;
    logic [3:0] b_q;
    logic       b_run;
    logic       b_carry;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    rw_step_counter #(.WIDTH(8), .STEP(1), .INIT(8'h00)) u_dut8 (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_op    (in_op),
        .in_data  (in_data),
        .out_q    (out_q),
        .out_run  (out_run),
        .out_carry(out_carry)
    );

    rw_step_counter #(.WIDTH(4), .STEP(3), .INIT(4'hD)) u_dut4 (
        .clk      (clk),
        .rst      (rst),
        .in_valid (b_valid),
        .in_op    (b_op),
        .in_data  (b_data),
        .out_q    (b_q),
        .out_run  (b_run),
        .out_carry(b_carry)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] q, input logic run, input logic c);
        chk({tag, ".q"}, 32'(out_q), 32'(q));
        chk({tag, ".run"}, 32'(out_run), 32'(run));
        chk({tag, ".carry"}, 32'(out_carry), 32'(c));
    endtask

    task automatic chk4(input string tag, input logic [3:0] q, input logic c);
        chk({tag, ".q"}, 32'(b_q), 32'(q));
        chk({tag, ".carry"}, 32'(b_carry), 32'(c));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic [1:0] op, input logic [7:0] data);
        in_valid = 1'b1;
        in_op    = op;
        in_data  = data;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_op    = 2'b10;
        in_data  = 8'h5A;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        b_valid = 1'b0;
        b_op    = 2'b00;
        b_data  = 4'h0;
        #12;
        chk8("reset", 8'h00, 1'b1, 1'b0);
        chk4("reset4", 4'hD, 1'b0);
        rst = 1'b0;

        // Free run from INIT; the 4-bit instance wraps on its first edge.
        tick(); chk8("run1", 8'h01, 1'b1, 1'b0);
`ifdef RW_STEP_COUNTER_SAT_EN
        chk4("s3_1", 4'hF, 1'b1);
`else
        chk4("s3_1", 4'h0, 1'b1);
`endif
        tick(); chk8("run2", 8'h02, 1'b1, 1'b0);
`ifdef RW_STEP_COUNTER_SAT_EN
        chk4("s3_2", 4'hF, 1'b0);
`else
        chk4("s3_2", 4'h3, 1'b0);
`endif
        tick(); chk8("run3", 8'h03, 1'b1, 1'b0);
`ifdef RW_STEP_COUNTER_SAT_EN
        chk4("s3_3", 4'hF, 1'b0);
`else
        chk4("s3_3", 4'h6, 1'b0);
`endif
        tick(); chk8("run4", 8'h04, 1'b1, 1'b0);
        tick(); chk8("run5", 8'h05, 1'b1, 1'b0);

        // Wrap / saturate at the top.
        cmd(2'b10, 8'hFE);
        tick(); chk8("ld_fe", 8'hFE, 1'b1, 1'b0);
        idle();
`ifdef RW_STEP_COUNTER_SAT_EN
        tick(); chk8("top1", 8'hFF, 1'b1, 1'b1);
        tick(); chk8("top2", 8'hFF, 1'b1, 1'b0);
        tick(); chk8("top3", 8'hFF, 1'b1, 1'b0);
`else
        tick(); chk8("top1", 8'hFF, 1'b1, 1'b0);
        tick(); chk8("top2", 8'h00, 1'b1, 1'b1);
        tick(); chk8("top3", 8'h01, 1'b1, 1'b0);
`endif

        // Pause, step while paused, resume.
        cmd(2'b10, 8'h10);
        tick(); chk8("ld_10", 8'h10, 1'b1, 1'b0);
        cmd(2'b11, 8'h00);
        tick(); chk8("pause", 8'h10, 1'b0, 1'b0);
        idle();
        for (int i = 0; i < 4; i++) begin
            tick(); chk8("paused_idle", 8'h10, 1'b0, 1'b0);
        end
        cmd(2'b00, 8'hEE);
        tick(); chk8("paused_step", 8'h11, 1'b0, 1'b0);
        cmd(2'b11, 8'hEE);
        tick(); chk8("resume", 8'h11, 1'b1, 1'b0);
        idle();
        tick(); chk8("resume1", 8'h12, 1'b1, 1'b0);
        tick(); chk8("resume2", 8'h13, 1'b1, 1'b0);

        // Decrement below zero, then one auto-advance.
        cmd(2'b10, 8'h00);
        tick(); chk8("ld_00", 8'h00, 1'b1, 1'b0);
        cmd(2'b01, 8'h77);
        tick();
`ifdef RW_STEP_COUNTER_SAT_EN
        chk8("dec0", 8'h00, 1'b1, 1'b1);
        idle();
        tick(); chk8("dec_after", 8'h01, 1'b1, 1'b0);
`else
        chk8("dec0", 8'hFF, 1'b1, 1'b1);
        idle();
        tick(); chk8("dec_after", 8'h00, 1'b1, 1'b1);
`endif

        // Asynchronous reset between edges while paused at 37.
        cmd(2'b10, 8'h37);
        tick(); chk8("ld_37", 8'h37, 1'b1, 1'b0);
        cmd(2'b11, 8'h00);
        tick(); chk8("pause37", 8'h37, 1'b0, 1'b0);
        cmd(2'b10, 8'hAA);
        #3;
        rst = 1'b1;
        #1;
        chk8("async_rst", 8'h00, 1'b1, 1'b0);
        chk4("async_rst4", 4'hD, 1'b0);
        tick(); chk8("rst_hold", 8'h00, 1'b1, 1'b0);
        rst = 1'b0;
        idle();
        tick(); chk8("rst_exit", 8'h01, 1'b1, 1'b0);
`ifdef RW_STEP_COUNTER_SAT_EN
        chk4("rst_exit4", 4'hF, 1'b1);
`else
        chk4("rst_exit4", 4'h0, 1'b1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
